stereo_job_sequencer: RTL and testbench

- Control stage directly upstream of a processing unit (FFT/magnitude core, or its simulation stand-in) that uses a Start-pulse / Busy / End-pulse handshake.
- On each completed stereo input frame, runs the unit twice: left channel, then right. Raises Done once both jobs have finished.
- Queues one frame arriving mid-job. Flags overrun beyond that.

---
 rtl/stereo_job_sequencer_pkg.sv | 18 +
 rtl/stereo_job_sequencer_watchdog.sv | 23 ++
 rtl/stereo_job_sequencer.sv | 85 ++++++++
 tb/tb_stereo_job_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_job_sequencer_pkg.sv
// stereo_seq_pkg: state encoding, channel codes and watchdog default for stereo_job_sequencer.
package stereo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_L,
        WAIT_L,
        START_R,
        WAIT_R,
        DONE
    } state_t;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    localparam int TIMEOUT_CYC_DEF = 50000;

endpackage

// File: rtl/stereo_job_sequencer_watchdog.sv
// seq_watchdog: cycle counter for a WAIT state, cleared on entry, tc on the last allowed cycle.
module seq_watchdog #(
    parameter int W    = 16,
    parameter int TERM = 50000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

    assign tc = en && cnt == W'(TERM - 1);

endmodule

// File: rtl/stereo_job_sequencer.sv
// stereo_job_sequencer: runs the unit on L then R per stereo frame, queues one extra frame.
// JOBSEQ_WATCHDOG_EN adds a WAIT-state timeout that sets the sticky Error flag.
module stereo_job_sequencer
    import stereo_seq_pkg::*;
`ifdef JOBSEQ_WATCHDOG_EN
#(
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
`endif
(
    input  logic Clock,
    input  logic Reset,
    input  logic FrameReady,
    input  logic UnitBusy,
    input  logic UnitEnd,
    output logic UnitStart,
    output logic UnitCh,
    output logic Busy,
    output logic Done,
    output logic Overrun,
    input  logic OverrunClr,
    output logic Error
);

    state_t state;
    logic   pending;
    logic   start_st;
    logic   start_now;
    logic   timeout;

    assign start_st  = state == START_L || state == START_R;
    assign start_now = (state == IDLE || state == DONE) && (pending || FrameReady);
    assign UnitStart = start_st && !UnitBusy;
    assign UnitCh    = (state == START_R || state == WAIT_R) ? CH_R : CH_L;
    assign Busy      = state != IDLE;
    assign Done      = state == DONE;

`ifdef JOBSEQ_WATCHDOG_EN
    logic wait_st;
    assign wait_st = state == WAIT_L || state == WAIT_R;

    seq_watchdog #(
        .W   (TIMEOUT_W),
        .TERM(TIMEOUT_CYC)
    ) u_watchdog (
        .Clock(Clock),
        .Reset(Reset),
        .clr  (UnitStart),
        .en   (wait_st),
        .tc   (timeout)
    );
`else
    assign timeout = 1'b0;
    assign Error   = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            Overrun <= 1'b0;
`ifdef JOBSEQ_WATCHDOG_EN
            Error   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:    state <= start_now ? START_L : IDLE;
                START_L: state <= UnitBusy ? START_L : WAIT_L;
                WAIT_L:  state <= UnitEnd ? START_R : timeout ? IDLE : WAIT_L;
                START_R: state <= UnitBusy ? START_R : WAIT_R;
                WAIT_R:  state <= UnitEnd ? DONE : timeout ? IDLE : WAIT_R;
                default: state <= start_now ? START_L : IDLE;
            endcase
            // a starting job consumes pending first; a simultaneous new frame takes its place
            pending <= start_now ? pending && FrameReady : pending || FrameReady;
            if (FrameReady && pending && !start_now) Overrun <= 1'b1;
            else if (OverrunClr) Overrun <= 1'b0;
`ifdef JOBSEQ_WATCHDOG_EN
            if (timeout && !UnitEnd) Error <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_stereo_job_sequencer.sv
// tb_stereo_job_sequencer: directed scenarios against a unit model whose End comes 6 cycles after Start is seen.
module tb_stereo_job_sequencer;

    logic Clock      = 1'b0;
    logic Reset      = 1'b1;
    logic FrameReady = 1'b0;
    logic OverrunClr = 1'b0;
    logic UnitBusy, UnitEnd;
    logic UnitStart, UnitCh, Busy, Done, Overrun, Error;

    int   n_chk  = 0;
    int   n_fail = 0;

    int   ucnt      = 0;
    logic model_rst = 1'b1;
    logic hold_busy = 1'b0;
    logic end_inj   = 1'b0;
    logic hang      = 1'b0;

    always #5 Clock = ~Clock;

    always @(posedge Clock)
        if (model_rst) ucnt <= 0;
        else if (UnitStart) ucnt <= 6;
        else if (ucnt > 0 && !hang) ucnt <= ucnt - 1;

    assign UnitBusy = ucnt != 0 || hold_busy;
    assign UnitEnd  = (ucnt == 1 && !hang) || end_inj;

`ifdef JOBSEQ_WATCHDOG_EN
    stereo_job_sequencer #(.TIMEOUT_CYC(20)) dut (
`else
    stereo_job_sequencer dut (
`endif
        .Clock     (Clock),
        .Reset     (Reset),
        .FrameReady(FrameReady),
        .UnitBusy  (UnitBusy),
        .UnitEnd   (UnitEnd),
        .UnitStart (UnitStart),
        .UnitCh    (UnitCh),
        .Busy      (Busy),
        .Done      (Done),
        .Overrun   (Overrun),
        .OverrunClr(OverrunClr),
        .Error     (Error)
    );

    task automatic do_reset;
        Reset      = 1'b1;
        FrameReady = 1'b0;
        OverrunClr = 1'b0;
        hold_busy  = 1'b0;
        end_inj    = 1'b0;
        hang       = 1'b0;
        model_rst  = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Reset     = 1'b0;
        model_rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] got;
        #3;
        got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
        n_chk++;
        if (got !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=%b", got, 6'b0);
        end
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge Clock);
            #3;
            got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
            n_chk++;
            if (got !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got=%b exp=%b", c, got, 6'b0);
            end
        end
    endtask

    task automatic test_single_frame;
        logic [5:0] got, exp;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            @(posedge Clock);
            #1;
            FrameReady = (c == 10);
            #2;
            got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
            exp = {c == 11 || c == 18, c >= 18 && c <= 24, c >= 11 && c <= 25, c == 25, 1'b0, 1'b0};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single c=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    // second frame either mid-job (pending) or in DONE (direct restart); both give the same trace
    task automatic test_back_to_back(input int fr2, input string tag);
        logic [5:0] got, exp;
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            @(posedge Clock);
            #1;
            FrameReady = (c == 10 || c == fr2);
            #2;
            got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
            exp = {c inside {11, 18, 26, 33}, (c >= 18 && c <= 24) || (c >= 33 && c <= 39),
                   c >= 11 && c <= 40, c == 25 || c == 40, 1'b0, 1'b0};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s c=%0d got=%b exp=%b", tag, c, got, exp);
            end
        end
    endtask

    task automatic test_overrun;
        logic [5:0] got, exp;
        do_reset();
        for (int c = 0; c <= 55; c++) begin
            @(posedge Clock);
            #1;
            FrameReady = (c == 10 || c == 13 || c == 15);
            OverrunClr = (c == 15 || c == 40);
            #2;
            got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
            exp = {c inside {11, 18, 26, 33}, (c >= 18 && c <= 24) || (c >= 33 && c <= 39),
                   c >= 11 && c <= 40, c == 25 || c == 40, c >= 16 && c <= 40, 1'b0};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL overrun c=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_busy_hold;
        logic [5:0] got, exp;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            @(posedge Clock);
            #1;
            FrameReady = (c == 10);
            hold_busy  = (c <= 17);
            #2;
            got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
            exp = {c == 18 || c == 25, c >= 25 && c <= 31, c >= 11 && c <= 32, c == 32, 1'b0, 1'b0};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL busy_hold c=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_reset_wait_r;
        logic [5:0] got, exp;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            @(posedge Clock);
            #1;
            FrameReady = (c == 10 || c == 13 || c == 15);
            Reset      = (c == 20 || c == 21);
            end_inj    = (c == 30);
            #2;
            got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
            exp = (c >= 20) ? 6'b0 : {c == 11 || c == 18, c >= 18, c >= 11, 1'b0, c >= 16, 1'b0};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_wait_r c=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

`ifdef JOBSEQ_WATCHDOG_EN
    task automatic test_watchdog;
        logic [5:0] got, exp;
        do_reset();
        hang = 1'b1;
        for (int c = 0; c <= 45; c++) begin
            @(posedge Clock);
            #1;
            FrameReady = (c == 10);
            #2;
            got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
            exp = {c == 11, 1'b0, c >= 11 && c <= 31, 1'b0, 1'b0, c >= 32};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL watchdog c=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask
`else
    task automatic test_no_watchdog;
        logic [5:0] got, exp;
        do_reset();
        hang = 1'b1;
        for (int c = 0; c <= 300; c++) begin
            @(posedge Clock);
            #1;
            FrameReady = (c == 10);
            #2;
            got = {UnitStart, UnitCh, Busy, Done, Overrun, Error};
            exp = {c == 11, 1'b0, c >= 11, 1'b0, 1'b0, 1'b0};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL no_watchdog c=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back(14, "frame_mid_job");
        test_back_to_back(25, "frame_in_done");
        test_overrun();
        test_busy_hold();
        test_reset_wait_r();
`ifdef JOBSEQ_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
